// File: rtl/cheriot_dv_pkg.sv
// Shared types and constants for the CHERIoT DV memory-transaction tracker.
// The optional TS-map flagging is controlled by CHERIOT_DV_MEMTRK_TSMAP_FLAG_EN.
package cheriot_dv_pkg;

    // Start of the tagged-memory (TS) map region and its size in bytes.
    localparam logic [31:0] TsMapStartAddr = 32'h8300_0000;
    localparam logic [31:0] TsMapSize      = 32'h0040_0000;

    // One completed data-bus transaction as reported to the DV environment.
    typedef struct packed {
        logic        is_cap;
        logic        we;
        logic [3:0]  be;
        logic [29:0] addr32;
        logic [32:0] wdata;
        logic [32:0] rdata;
        logic        err;
        logic [7:0]  flag;
    } mem_cmd_t;

    // Request-side fields captured at grant time and held until the response.
    typedef struct packed {
        logic        is_cap;
        logic        we;
        logic [3:0]  be;
        logic [29:0] addr32;
        logic [32:0] wdata;
    } memtrk_req_t;

    typedef enum logic [1:0] {
        MEMTRK_IDLE  = 2'd0,
        MEMTRK_BUSY  = 2'd1,
        MEMTRK_FAULT = 2'd2
    } memtrk_state_t;

    typedef enum logic [1:0] {
        MEMTRK_FAULT_NONE     = 2'd0,
        MEMTRK_FAULT_OVERFLOW = 2'd1,
        MEMTRK_FAULT_ORPHAN   = 2'd2
    } memtrk_fault_e;

    // Word-address range check against the TS map; the region is word aligned,
    // so comparing addr[31:2] is exact.
    function automatic logic tsMapHit(input logic [29:0] addr32);
        logic [31:0] startAddr;
        logic [31:0] endAddr;
        startAddr = TsMapStartAddr;
        endAddr   = TsMapStartAddr + TsMapSize;
        return (addr32 >= startAddr[31:2]) && (addr32 < endAddr[31:2]);
    endfunction

endpackage

// File: rtl/cheriot_dv_cmd_fifo.sv
// In-order ring-buffer FIFO holding granted requests awaiting their response.
// Pointers wrap naturally because DEPTH is a power of two.
module cheriot_dv_cmd_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  T                       push_data_i,
    input  logic                   pop_i,
    output T                       head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int            PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);

    T                r_mem [DEPTH];
    logic [PtrW-1:0] r_wrPtr;
    logic [PtrW-1:0] r_rdPtr;
    logic [PtrW:0]   r_count;
    logic            w_doPush;
    logic            w_doPop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal alongside it.
    assign w_doPop  = pop_i && (r_count != '0);
    assign w_doPush = push_i && ((r_count != Full) || w_doPop);

    // Payload storage; validity is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk_i) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= push_data_i;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_rdPtr];
    assign count_o = r_count;

endmodule

// File: rtl/cheriot_dv_mem_tracker.sv
// Snoops the Ibex data bus, pairs each grant with its in-order response and
// emits one completed-transaction record per response. Protocol errors
// (overflow, orphan response) latch a sticky fault until reset.
// Define CHERIOT_DV_MEMTRK_TSMAP_FLAG_EN to mark accesses into the TS map in flag[0].
module cheriot_dv_mem_tracker
    import cheriot_dv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   data_req_i,
    input  logic                   data_gnt_i,
    input  logic                   data_rvalid_i,
    input  logic                   data_we_i,
    input  logic [3:0]             data_be_i,
    input  logic [31:0]            data_addr_i,
    input  logic [32:0]            data_wdata_i,
    input  logic                   data_is_cap_i,
    input  logic [32:0]            data_rdata_i,
    input  logic                   data_err_i,
    output logic                   cmd_valid_o,
    output mem_cmd_t               cmd_o,
    output logic [$clog2(DEPTH):0] outstanding_o,
    output logic [CNT_W-1:0]       txn_cnt_o,
    output logic                   fault_o,
    output logic [1:0]             fault_code_o
);
    localparam int            CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    memtrk_state_t   r_state;
    memtrk_fault_e   r_faultCode;
    logic            r_cmdValid;
    mem_cmd_t        r_cmd;
    logic [CNT_W-1:0] r_txnCnt;
    logic            r_fault;

    memtrk_req_t     w_reqEntry;
    memtrk_req_t     w_head;
    logic [CntW-1:0] w_count;
    logic [CntW-1:0] w_nextCount;
    logic            w_grant;
    logic            w_pop;
    logic            w_push;
    logic            w_orphan;
    logic            w_overflow;
    logic            w_tsHit;
    mem_cmd_t        w_cmd;

    assign w_grant    = data_req_i && data_gnt_i;
    assign w_pop      = data_rvalid_i && (w_count != '0);
    assign w_orphan   = data_rvalid_i && (w_count == '0);
    assign w_overflow = w_grant && (w_count == Full) && !w_pop;
    assign w_push     = w_grant && !w_overflow;

    assign w_reqEntry.is_cap = data_is_cap_i;
    assign w_reqEntry.we     = data_we_i;
    assign w_reqEntry.be     = data_be_i;
    assign w_reqEntry.addr32 = data_addr_i[31:2];
    assign w_reqEntry.wdata  = data_wdata_i;

    cheriot_dv_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (memtrk_req_t)
    ) u_pendFifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_reqEntry),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count)
    );

`ifdef CHERIOT_DV_MEMTRK_TSMAP_FLAG_EN
    assign w_tsHit = tsMapHit(w_head.addr32);
`else
    assign w_tsHit = 1'b0;
`endif

    // Merge the oldest pending request with the response beat arriving now.
    always_comb begin
        w_cmd        = '0;
        w_cmd.is_cap = w_head.is_cap;
        w_cmd.we     = w_head.we;
        w_cmd.be     = w_head.be;
        w_cmd.addr32 = w_head.addr32;
        w_cmd.wdata  = w_head.wdata;
        w_cmd.rdata  = data_rdata_i;
        w_cmd.err    = data_err_i;
        w_cmd.flag   = {7'b0, w_tsHit};
    end

    // Occupancy after this cycle, used to steer IDLE/BUSY.
    always_comb begin
        w_nextCount = w_count;
        if (w_push && !w_pop) begin
            w_nextCount = w_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_nextCount = w_count - 1'b1;
        end
    end

    // Tracker FSM with registered record, counter and sticky fault outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= MEMTRK_IDLE;
            r_faultCode <= MEMTRK_FAULT_NONE;
            r_cmdValid  <= 1'b0;
            r_cmd       <= '0;
            r_txnCnt    <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_cmdValid <= 1'b0;
            case (r_state)
                MEMTRK_FAULT: begin
                    r_state <= MEMTRK_FAULT;
                end
                default: begin
                    if (w_overflow || w_orphan) begin
                        r_state     <= MEMTRK_FAULT;
                        r_fault     <= 1'b1;
                        r_faultCode <= w_overflow ? MEMTRK_FAULT_OVERFLOW : MEMTRK_FAULT_ORPHAN;
                    end else begin
                        r_state <= (w_nextCount == '0) ? MEMTRK_IDLE : MEMTRK_BUSY;
                        if (w_pop) begin
                            r_cmdValid <= 1'b1;
                            r_cmd      <= w_cmd;
                            r_txnCnt   <= r_txnCnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign cmd_valid_o   = r_cmdValid;
    assign cmd_o         = r_cmd;
    assign outstanding_o = w_count;
    assign txn_cnt_o     = r_txnCnt;
    assign fault_o       = r_fault;
    assign fault_code_o  = r_faultCode;

endmodule

// File: tb/tb_cheriot_dv_mem_tracker.sv
// Directed self-checking bench for cheriot_dv_mem_tracker with a scoreboard of
// expected completion records. Works with or without CHERIOT_DV_MEMTRK_TSMAP_FLAG_EN.
module tb_cheriot_dv_mem_tracker;
    import cheriot_dv_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        data_req_i = 1'b0;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [32:0] data_wdata_i = '0;
    logic        data_is_cap_i = 1'b0;
    logic [32:0] data_rdata_i = '0;
    logic        data_err_i = 1'b0;
    logic        cmd_valid_o;
    mem_cmd_t    cmd_o;
    logic [$clog2(DEPTH):0] outstanding_o;
    logic [CNT_W-1:0]       txn_cnt_o;
    logic        fault_o;
    logic [1:0]  fault_code_o;

    int          assertCnt;
    int          failCnt;
    mem_cmd_t    pendQ[$];
    mem_cmd_t    expQ[$];
    logic        expPulse;
    logic [31:0] expTxn;
    logic        expFault;
    logic [1:0]  expCode;

    // Free-running clock, 10 time units per period.
    always #5 clk_i = ~clk_i;

    cheriot_dv_mem_tracker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .data_req_i    (data_req_i),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_we_i     (data_we_i),
        .data_be_i     (data_be_i),
        .data_addr_i   (data_addr_i),
        .data_wdata_i  (data_wdata_i),
        .data_is_cap_i (data_is_cap_i),
        .data_rdata_i  (data_rdata_i),
        .data_err_i    (data_err_i),
        .cmd_valid_o   (cmd_valid_o),
        .cmd_o         (cmd_o),
        .outstanding_o (outstanding_o),
        .txn_cnt_o     (txn_cnt_o),
        .fault_o       (fault_o),
        .fault_code_o  (fault_code_o)
    );

    function automatic logic [7:0] expFlag(input logic [29:0] a);
`ifdef CHERIOT_DV_MEMTRK_TSMAP_FLAG_EN
        logic [31:0] b;
        b = {a, 2'b00};
        return ((b >= 32'h8300_0000) && (b < 32'h8340_0000)) ? 8'h01 : 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCmd(input string tag, input mem_cmd_t obs, input mem_cmd_t exp);
        assertCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        pendQ.delete();
        expQ.delete();
        expPulse = 1'b0;
        expTxn   = '0;
        expFault = 1'b0;
        expCode  = 2'd0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cmd_valid"}, 64'(cmd_valid_o), 64'd0);
        checkCmd({tag, "_cmd"}, cmd_o, '0);
        checkOutput({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
        checkOutput({tag, "_txn_cnt"}, 64'(txn_cnt_o), 64'd0);
        checkOutput({tag, "_fault"}, 64'(fault_o), 64'd0);
        checkOutput({tag, "_fault_code"}, 64'(fault_code_o), 64'd0);
    endtask

    // Drive one cycle of bus activity, update the reference, then check after the edge.
    task automatic applyStimulus(input logic req, input logic gnt, input logic we,
                                 input logic [3:0] be, input logic [31:0] addr,
                                 input logic [32:0] wdata, input logic isCap,
                                 input logic rvalid, input logic [32:0] rdata, input logic err);
        mem_cmd_t e;
        logic     popping;
        logic     orphan;
        logic     granted;
        logic     overflow;
        data_req_i    = req;
        data_gnt_i    = gnt;
        data_we_i     = we;
        data_be_i     = be;
        data_addr_i   = addr;
        data_wdata_i  = wdata;
        data_is_cap_i = isCap;
        data_rvalid_i = rvalid;
        data_rdata_i  = rdata;
        data_err_i    = err;

        popping  = rvalid && (pendQ.size() > 0);
        orphan   = rvalid && (pendQ.size() == 0);
        granted  = req && gnt;
        overflow = granted && (pendQ.size() == DEPTH) && !popping;
        expPulse = 1'b0;
        if (popping) begin
            e       = pendQ.pop_front();
            e.rdata = rdata;
            e.err   = err;
            e.flag  = expFlag(e.addr32);
            if (!expFault) begin
                expQ.push_back(e);
                expPulse = 1'b1;
            end
        end
        if (granted && !overflow) begin
            e        = '0;
            e.is_cap = isCap;
            e.we     = we;
            e.be     = be;
            e.addr32 = addr[31:2];
            e.wdata  = wdata;
            pendQ.push_back(e);
        end
        if (!expFault && (overflow || orphan)) begin
            expFault = 1'b1;
            expCode  = overflow ? 2'd1 : 2'd2;
        end

        @(posedge clk_i);
        #1;
        checkOutput("cmd_valid", 64'(cmd_valid_o), 64'(expPulse));
        if (expPulse) begin
            expTxn = expTxn + 1;
            checkCmd("cmd_record", cmd_o, expQ.pop_front());
        end
        checkOutput("txn_cnt", 64'(txn_cnt_o), 64'(expTxn));
        checkOutput("outstanding", 64'(outstanding_o), 64'(pendQ.size()));
        checkOutput("fault", 64'(fault_o), 64'(expFault));
        checkOutput("fault_code", 64'(fault_code_o), 64'(expCode));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0, 1'b0, 1'b0, 33'h0, 1'b0);
    endtask

    task automatic grantOnly(input logic we, input logic [31:0] addr, input logic [32:0] wdata, input logic isCap);
        applyStimulus(1'b1, 1'b1, we, 4'hF, addr, wdata, isCap, 1'b0, 33'h0, 1'b0);
    endtask

    task automatic respondOnly(input logic [32:0] rdata, input logic err);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 33'h0, 1'b0, 1'b1, rdata, err);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge can occur.
    task automatic resetDut(input string tag);
        #2;
        rst_i = 1'b1;
        data_req_i = 1'b0;
        data_gnt_i = 1'b0;
        data_rvalid_i = 1'b0;
        #1;
        checkResetOutputs(tag);
        clearModel();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    logic [31:0] tsAddr [5];
    logic [7:0]  tsFlagOn [5];

    initial begin
        assertCnt = 0;
        failCnt   = 0;
        clearModel();
        tsAddr   = '{32'h8300_0100, 32'h8000_0000, 32'h8300_0000, 32'h833F_FFFC, 32'h8340_0000};
        tsFlagOn = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00};

        // Power-on reset
        #1;
        checkResetOutputs("por");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idleCycle();

        // Single write with latency-1 completion
        $display("[TB] single transaction");
        grantOnly(1'b1, 32'h8000_0010, 33'h1_DEAD_BEEF, 1'b0);
        idleCycle();
        respondOnly(33'h0_1234_5678, 1'b0);
        checkOutput("single_addr32", 64'(cmd_o.addr32), 64'h2000_0004);
        checkOutput("single_is_cap", 64'(cmd_o.is_cap), 64'd0);
        checkOutput("single_wdata", 64'(cmd_o.wdata), 64'h1_DEAD_BEEF);
        checkOutput("single_txn", 64'(txn_cnt_o), 64'd1);

        // Request without grant leaves state untouched
        applyStimulus(1'b1, 1'b0, 1'b1, 4'hF, 32'h8000_0040, 33'h5, 1'b0, 1'b0, 33'h0, 1'b0);
        checkOutput("req_no_gnt", 64'(outstanding_o), 64'd0);

        // Four back-to-back grants then four in-order responses
        $display("[TB] back-to-back");
        for (int i = 0; i < 4; i++) begin
            grantOnly(1'b0, 32'h8000_0100 + 32'(i * 4), 33'h0, i[0]);
        end
        checkOutput("b2b_full", 64'(outstanding_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            respondOnly(33'(i + 1), 1'b0);
            checkOutput("b2b_rdata", 64'(cmd_o.rdata), 64'(i + 1));
            checkOutput("b2b_outstanding", 64'(outstanding_o), 64'(3 - i));
        end
        idleCycle();
        checkOutput("b2b_txn", 64'(txn_cnt_o), 64'd5);

        // Full FIFO: simultaneous grant and response is legal, extra grant overflows
        $display("[TB] overflow");
        for (int i = 0; i < 4; i++) begin
            grantOnly(1'b1, 32'h8000_0200 + 32'(i * 4), 33'(i + 16), 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h3, 32'h8000_0300, 33'h1_0000_0001, 1'b1, 1'b1, 33'h55, 1'b1);
        checkOutput("full_swap_fault", 64'(fault_o), 64'd0);
        checkOutput("full_swap_outstanding", 64'(outstanding_o), 64'd4);
        grantOnly(1'b0, 32'h8000_0400, 33'h0, 1'b0);
        checkOutput("ovf_fault", 64'(fault_o), 64'd1);
        checkOutput("ovf_code", 64'(fault_code_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            respondOnly(33'(i + 100), 1'b0);
        end
        respondOnly(33'h9, 1'b0);
        checkOutput("ovf_code_kept", 64'(fault_code_o), 64'd1);
        checkOutput("ovf_txn_frozen", 64'(txn_cnt_o), 64'd6);
        resetDut("rst_after_ovf");

        // Orphan response with a same-cycle grant
        $display("[TB] orphan");
        applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 32'h8000_0500, 33'h0, 1'b0, 1'b1, 33'h7, 1'b0);
        checkOutput("orphan_code", 64'(fault_code_o), 64'd2);
        checkOutput("orphan_outstanding", 64'(outstanding_o), 64'd1);
        resetDut("rst_after_orphan");

        // TS-map flag over addresses in and around the region
        $display("[TB] ts map flag");
        for (int i = 0; i < 5; i++) begin
            grantOnly(1'b0, tsAddr[i], 33'h0, 1'b1);
            respondOnly(33'(i), 1'b0);
`ifdef CHERIOT_DV_MEMTRK_TSMAP_FLAG_EN
            checkOutput("ts_flag", 64'(cmd_o.flag), 64'(tsFlagOn[i]));
`else
            checkOutput("ts_flag", 64'(cmd_o.flag), 64'd0);
`endif
        end

        // Reset with three outstanding while a completion pulse is visible
        $display("[TB] reset mid-operation");
        grantOnly(1'b1, 32'h8000_0600, 33'h1, 1'b0);
        grantOnly(1'b1, 32'h8000_0604, 33'h2, 1'b0);
        grantOnly(1'b1, 32'h8000_0608, 33'h3, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 32'h8000_060C, 33'h4, 1'b0, 1'b1, 33'hA, 1'b0);
        checkOutput("pre_rst_outstanding", 64'(outstanding_o), 64'd3);
        resetDut("rst_mid_op");
        respondOnly(33'hB, 1'b0);
        checkOutput("post_rst_orphan_code", 64'(fault_code_o), 64'd2);

        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
